// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encodings,
// prefix byte constants, frame geometry and a parity helper.
package ps2_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes: extended key and key release
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  // Device-to-host frame: start + 8 data + parity + stop
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  // Odd parity: data bits together with the parity bit must XOR to 1
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample glitch filter for
// one asynchronous PS/2 line. The filtered level starts at 1 (idle bus) and
// only changes after FILTER_LEN consecutive samples of the opposite value.
// 'fall' is a registered one-cycle pulse coincident with a 1->0 change of
// the filtered level.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          fall_q,  fall_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Next-state: synchronizer shift, run-length count of disagreeing samples
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    fall_d = level_q & ~level_d;
  end

  // State registers; idle bus level is 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Host-side PS/2 keyboard receiver. Filters PS2_CLK/PS2_DAT, deframes
// 11-bit device-to-host frames (start, 8 data LSB first, odd parity, stop),
// checks parity/start/stop and an inter-bit timeout, and presents bytes in a
// 1-deep valid/ack holding register with overrun detection.
// Optional feature macro PS2_EXT_DECODE_EN: absorbs E0/F0 prefix bytes and
// reports them as key_ext/key_rel alongside the next delivered byte.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic       clock_25,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       key_ext,
  output logic       key_rel,
  output logic       err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned    TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]     BIT_LAST = 3'(PS2_DATA_BITS - 1);

  // Filtered lines
  logic clk_level_s, clk_fall_s;
  logic dat_level_s, dat_fall_s;
  logic unused_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clock_25),
    .rst_n (reset_n),
    .din   (ps2_clk),
    .level (clk_level_s),
    .fall  (clk_fall_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk   (clock_25),
    .rst_n (reset_n),
    .din   (ps2_dat),
    .level (dat_level_s),
    .fall  (dat_fall_s)
  );

  // Only the clock fall and the data level carry protocol meaning
  assign unused_s = &{1'b0, clk_level_s, dat_fall_s};

  // Receive state and output register
  ps2_state_e    state_q,      state_d;
  logic [2:0]    bit_cnt_q,    bit_cnt_d;
  logic [7:0]    shift_q,      shift_d;
  logic          par_bit_q,    par_bit_d;
  logic [TW-1:0] tmo_q,        tmo_d;
  logic [7:0]    data_q,       data_d;
  logic          data_valid_q, data_valid_d;
  logic          err_q,        err_d;
  logic          overrun_q,    overrun_d;
  logic          busy_q,       busy_d;
  logic          frame_ok_s;
  logic          deliver_s;
`ifdef PS2_EXT_DECODE_EN
  logic          ext_pend_q,   ext_pend_d;
  logic          rel_pend_q,   rel_pend_d;
  logic          key_ext_q,    key_ext_d;
  logic          key_rel_q,    key_rel_d;
`endif

  // Next-state: deframing FSM, timeout, holding register and prefix flags
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    tmo_d        = tmo_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    err_d        = 1'b0;
    overrun_d    = 1'b0;
    frame_ok_s   = 1'b0;
    deliver_s    = 1'b0;
`ifdef PS2_EXT_DECODE_EN
    ext_pend_d   = ext_pend_q;
    rel_pend_d   = rel_pend_q;
    key_ext_d    = key_ext_q;
    key_rel_d    = key_rel_q;
`endif

    // Consumer takes the byte; ack with nothing held is ignored
    if (data_ack && data_valid_q) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end

    // Inter-bit timer: restarts on each fall, runs only inside a frame
    if (clk_fall_s) begin
      tmo_d = {TW{1'b0}};
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = {TW{1'b0}};
    end

    case (state_q)
      ST_IDLE: begin
        if (clk_fall_s) begin
          if (!dat_level_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (clk_fall_s) begin
          shift_d = {dat_level_s, shift_q[7:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (clk_fall_s) begin
          par_bit_d = dat_level_s;
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (clk_fall_s) begin
          state_d = ST_IDLE;
          if (dat_level_s && odd_parity_ok(shift_q, par_bit_q)) begin
            frame_ok_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-bit timeout abandons the partial frame
    if ((state_q != ST_IDLE) && !clk_fall_s && (tmo_q == TMO_LAST)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = {TW{1'b0}};
    end else begin
      tmo_d = tmo_d;
    end

    // Good frame: prefix bytes are absorbed when decoding is enabled
    if (frame_ok_s) begin
`ifdef PS2_EXT_DECODE_EN
      if (shift_q == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == PS2_REL) begin
        rel_pend_d = 1'b1;
      end else begin
        deliver_s = 1'b1;
      end
`else
      deliver_s = 1'b1;
`endif
    end else begin
      deliver_s = 1'b0;
    end

    // Delivery into the holding register; same-cycle ack frees the slot
    if (deliver_s) begin
      if (!data_valid_q || data_ack) begin
        data_d       = shift_q;
        data_valid_d = 1'b1;
`ifdef PS2_EXT_DECODE_EN
        key_ext_d    = ext_pend_q;
        key_rel_d    = rel_pend_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
`ifdef PS2_EXT_DECODE_EN
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
`endif
    end else begin
      overrun_d = 1'b0;
    end

`ifdef PS2_EXT_DECODE_EN
    // Any error also forgets a pending prefix
    if (err_d) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else begin
      ext_pend_d = ext_pend_d;
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bit_q    <= 1'b0;
      tmo_q        <= {TW{1'b0}};
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PS2_EXT_DECODE_EN
      ext_pend_q   <= 1'b0;
      rel_pend_q   <= 1'b0;
      key_ext_q    <= 1'b0;
      key_rel_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef PS2_EXT_DECODE_EN
      ext_pend_q   <= ext_pend_d;
      rel_pend_q   <= rel_pend_d;
      key_ext_q    <= key_ext_d;
      key_rel_q    <= key_rel_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign err        = err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;
`ifdef PS2_EXT_DECODE_EN
  assign key_ext    = key_ext_q;
  assign key_rel    = key_rel_q;
`else
  assign key_ext    = 1'b0;
  assign key_rel    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx. The PS/2 device model toggles the
// clock every H system cycles and changes data in the middle of the high
// phase. FILTER_LEN=8, TIMEOUT_CYC=2000.
module tb_ps2_keyboard_rx;

  localparam int H = 40;  // ps2 half period in system cycles
  localparam int Q = 20;  // data change point inside the high phase

  logic       clock_25 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid, key_ext, key_rel, err, overrun, busy;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;

  always #20 clock_25 = ~clock_25;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(2000)) dut (
    .clock_25   (clock_25),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .key_ext    (key_ext),
    .key_rel    (key_rel),
    .err        (err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Count one-cycle pulses away from the active edge
  always @(negedge clock_25) begin
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (err === 1'b1 && overrun === 1'b1) both_cnt <= both_cnt + 1;
  end

  // Global time limit
  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock_25);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Drive the first nbits of a frame; optionally ack in the delivery cycle
  task automatic send_bits(input logic [10:0] fr, input int nbits, input logic ack_on_stop);
    for (int i = 0; i < nbits; i++) begin
      wait_cyc(Q);
      ps2_dat = fr[i];
      wait_cyc(Q);
      ps2_clk = 1'b0;
      if (ack_on_stop && i == 10) begin
        repeat (10) @(posedge clock_25);
        @(negedge clock_25);
        data_ack = 1'b1;
        @(negedge clock_25);
        data_ack = 1'b0;
        wait_cyc(H - 12);
      end else begin
        wait_cyc(H);
      end
      ps2_clk = 1'b1;
    end
    wait_cyc(Q);
    ps2_dat = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11, 1'b0);
  endtask

  task automatic do_ack();
    @(negedge clock_25);
    data_ack = 1'b1;
    @(negedge clock_25);
    data_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(3);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    checks++; if (key_ext !== 1'b0 || key_rel !== 1'b0) begin errors++; $display("FAIL reset_keys: got %b%b expected 00", key_ext, key_rel); end
    checks++; if (err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got err=%b ovr=%b expected 0 0", err, overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_cnt;
    send_byte(8'h1C);
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL basic_data: got %h expected 1c", data); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", data_valid); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL basic_err: got %0d pulses expected 0", err_cnt - e0); end
    checks++; if (key_ext !== 1'b0 || key_rel !== 1'b0) begin errors++; $display("FAIL basic_keys: got %b%b expected 00", key_ext, key_rel); end
    @(negedge clock_25);
    data_ack = 1'b1;
    @(posedge clock_25);
    #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got valid %b expected 0", data_valid); end
    @(negedge clock_25);
    data_ack = 1'b0;
    do_ack();
    wait_cyc(2);
    checks++; if (data_valid !== 1'b0 || data !== 8'h1C) begin errors++; $display("FAIL idle_ack: got valid %b data %h expected 0 1c", data_valid, data); end
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_cnt;
    send_bits(mk_frame(8'h5A, 1'b1), 11, 1'b0);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL parity_err: got %0d pulses expected 1", err_cnt - e0); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL parity_valid: got %b expected 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overrun();
    int o0;
    send_byte(8'h1C);
    o0 = ovr_cnt;
    send_byte(8'h32);
    checks++; if (ovr_cnt !== o0 + 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulses expected 1", ovr_cnt - o0); end
    checks++; if (data !== 8'h1C || data_valid !== 1'b1) begin errors++; $display("FAIL ovr_keep: got %h/%b expected 1c/1", data, data_valid); end
    send_bits(mk_frame(8'h32, 1'b0), 11, 1'b1);
    checks++; if (ovr_cnt !== o0 + 1) begin errors++; $display("FAIL ack_same_ovr: got %0d pulses expected 1", ovr_cnt - o0); end
    checks++; if (data !== 8'h32 || data_valid !== 1'b1) begin errors++; $display("FAIL ack_same_data: got %h/%b expected 32/1", data, data_valid); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL err_ovr_both: got %0d expected 0", both_cnt); end
    do_ack();
  endtask

  task automatic test_timeout();
    int e0;
    int n;
    e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 1'b0), 5, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_mid: got %b expected 1", busy); end
    n = 0;
    while (err_cnt == e0 && n < 2500) begin
      @(negedge clock_25);
      n++;
    end
    wait_cyc(2);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL tmo_err: got %0d pulses expected 1 (waited %0d)", err_cnt - e0, n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy %b expected 0", busy); end
    send_byte(8'h1C);
    checks++; if (data !== 8'h1C || data_valid !== 1'b1 || err_cnt !== e0 + 1) begin errors++; $display("FAIL tmo_next: got %h/%b errs %0d expected 1c/1 1", data, data_valid, err_cnt - e0); end
    do_ack();
  endtask

  task automatic test_ext();
`ifdef PS2_EXT_DECODE_EN
    send_byte(8'hE0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ext_e0_absorb: got valid %b expected 0", data_valid); end
    send_byte(8'hF0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ext_f0_absorb: got valid %b expected 0", data_valid); end
    send_byte(8'h75);
    checks++; if (data !== 8'h75 || data_valid !== 1'b1) begin errors++; $display("FAIL ext_data: got %h/%b expected 75/1", data, data_valid); end
    checks++; if (key_ext !== 1'b1 || key_rel !== 1'b1) begin errors++; $display("FAIL ext_keys: got %b%b expected 11", key_ext, key_rel); end
    do_ack();
`else
    logic [7:0] seq [3];
    seq[0] = 8'hE0;
    seq[1] = 8'hF0;
    seq[2] = 8'h75;
    for (int k = 0; k < 3; k++) begin
      send_byte(seq[k]);
      checks++; if (data !== seq[k] || data_valid !== 1'b1) begin errors++; $display("FAIL raw_data%0d: got %h/%b expected %h/1", k, data, data_valid, seq[k]); end
      checks++; if (key_ext !== 1'b0 || key_rel !== 1'b0) begin errors++; $display("FAIL raw_keys%0d: got %b%b expected 00", k, key_ext, key_rel); end
      do_ack();
    end
`endif
  endtask

  task automatic test_glitch_reset();
    int e0;
    e0 = err_cnt;
    @(negedge clock_25);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    checks++; if (busy !== 1'b0 || err_cnt !== e0 || data_valid !== 1'b0) begin errors++; $display("FAIL glitch: got busy %b errs %0d valid %b expected 0 0 0", busy, err_cnt - e0, data_valid); end
    send_bits(mk_frame(8'h32, 1'b0), 4, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_mid: got %b expected 1", busy); end
    @(negedge clock_25);
    reset_n = 1'b0;
    wait_cyc(3);
    checks++; if (data !== 8'h00 || data_valid !== 1'b0 || busy !== 1'b0 || key_ext !== 1'b0 || key_rel !== 1'b0 || err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got data %h valid %b busy %b ext %b rel %b err %b ovr %b expected all 0", data, data_valid, busy, key_ext, key_rel, err, overrun); end
    reset_n = 1'b1;
    wait_cyc(5);
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL rst_no_pulse: got %0d err pulses expected 0", err_cnt - e0); end
    send_byte(8'h1C);
    checks++; if (data !== 8'h1C || data_valid !== 1'b1 || err_cnt !== e0) begin errors++; $display("FAIL rst_next: got %h/%b errs %0d expected 1c/1 0", data, data_valid, err_cnt - e0); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overrun();
    test_timeout();
    test_ext();
    test_glitch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
